// File: rtl/csr_file.sv
// Write-back stage CSR file: the tohost register plus the 64-bit cycle/instret
// counters, with combinational read data for the write-back mux.
module csr_file #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter int          CNT_W       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        valid_w,
  input  logic        csr_we,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        tohost_wr
);

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  logic             commit;
  logic             src_ok;
  logic [31:0]      wr_data;
  logic             wr_en;
  logic [31:0]      tohost_q;
  logic             tohost_wr_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  assign commit = valid_w & ~stall;

  // Only the two write-only CSR forms carry a source; anything else writes nothing.
  always_comb begin
    src_ok  = 1'b0;
    wr_data = '0;
    case (funct3)
      F3_CSRRW: begin
        src_ok  = 1'b1;
        wr_data = rs1_data;
      end
      F3_CSRRWI: begin
        src_ok  = 1'b1;
        wr_data = {27'b0, zimm};
      end
      default: ;
    endcase
  end

  assign wr_en = commit & csr_we & src_ok & (csr_addr == TOHOST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_q    <= '0;
      tohost_wr_q <= 1'b0;
    end else begin
      tohost_wr_q <= wr_en;
      if (wr_en) tohost_q <= wr_data;
    end
  end

  // Full-width adds so the low-to-high word carry lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (commit) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Reads see pre-write state, which gives CSRRW its old-value semantics.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      TOHOST_ADDR:     csr_rdata = tohost_q;
      12'hC00, 12'hB00: csr_rdata = cycle_q[31:0];
      12'hC80, 12'hB80: csr_rdata = cycle_q[CNT_W-1:32];
      12'hC02, 12'hB02: csr_rdata = instret_q[31:0];
      12'hC82, 12'hB82: csr_rdata = instret_q[CNT_W-1:32];
      default:          csr_rdata = '0;
    endcase
  end

  assign tohost    = tohost_q;
  assign tohost_wr = tohost_wr_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset, CSRRW/CSRRWI writes, stalls, counter
// carry and ignored writes, each scenario checking its own expectations.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        valid_w;
  logic        csr_we;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        tohost_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_cycle;
  logic [63:0] exp_instret;

  csr_file dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .valid_w(valid_w),
    .csr_we(csr_we), .funct3(funct3), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .zimm(zimm), .csr_rdata(csr_rdata),
    .tohost(tohost), .tohost_wr(tohost_wr)
  );

  always #5 clk = ~clk;

  // Reference counters: cycle counts every edge out of reset, instret every commit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cycle   <= 64'd0;
      exp_instret <= 64'd0;
    end else begin
      exp_cycle <= exp_cycle + 64'd1;
      if (valid_w && !stall) exp_instret <= exp_instret + 64'd1;
    end
  end

  task automatic idle();
    valid_w = 1'b0; csr_we = 1'b0; stall = 1'b0;
    funct3 = 3'b000; rs1_data = 32'h0; zimm = 5'h0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1 d = csr_rdata;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] r, input logic [4:0] z);
    valid_w = 1'b1; csr_we = 1'b1; funct3 = f3;
    csr_addr = a; rs1_data = r; zimm = z;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle();
    csr_addr = 12'hC00;
    rst_n = 1'b0;
    #23;
    vectors++; if (tohost !== 32'h0) begin miscompares++; $display("FAIL reset_tohost got %h want %h", tohost, 32'h0); end
    vectors++; if (tohost_wr !== 1'b0) begin miscompares++; $display("FAIL reset_tohost_wr got %b want 0", tohost_wr); end
    rd(12'hC00, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_cycle got %h want 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(12'hC00, d);
    vectors++; if (d !== 32'd10) begin miscompares++; $display("FAIL count_cycle got %0d want 10", d); end
    rd(12'hC02, d);
    vectors++; if (d !== 32'd0) begin miscompares++; $display("FAIL count_instret got %0d want 0", d); end
    vectors++; if (tohost !== 32'h0) begin miscompares++; $display("FAIL count_tohost got %h want 0", tohost); end
  endtask

  task automatic test_csrrw();
    logic [31:0] d;
    @(negedge clk);
    issue(3'b001, 12'h51E, 32'hDEADBEEF, 5'h0);
    #1;
    vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL csrrw_old got %h want 0", csr_rdata); end
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'hDEADBEEF) begin miscompares++; $display("FAIL csrrw_tohost got %h want deadbeef", tohost); end
    vectors++; if (tohost_wr !== 1'b1) begin miscompares++; $display("FAIL csrrw_pulse got %b want 1", tohost_wr); end
    rd(12'h51E, d);
    vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL csrrw_rdata got %h want deadbeef", d); end
    @(negedge clk);
    vectors++; if (tohost_wr !== 1'b0) begin miscompares++; $display("FAIL csrrw_pulse_end got %b want 0", tohost_wr); end
    rd(12'hC02, d);
    vectors++; if (d !== 32'd1) begin miscompares++; $display("FAIL csrrw_instret got %0d want 1", d); end
  endtask

  task automatic test_csrrwi();
    @(negedge clk);
    issue(3'b101, 12'h51E, 32'hFFFF_FFFF, 5'h1F);
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h0000001F) begin miscompares++; $display("FAIL csrrwi_tohost got %h want 0000001f", tohost); end
    vectors++; if (tohost_wr !== 1'b1) begin miscompares++; $display("FAIL csrrwi_pulse got %b want 1", tohost_wr); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(3'b001, 12'h51E, 32'h0000_000A, 5'h0);
    @(negedge clk);
    issue(3'b001, 12'h51E, 32'h0000_000B, 5'h0);
    vectors++; if (tohost !== 32'hA || tohost_wr !== 1'b1) begin miscompares++; $display("FAIL b2b_first got %h/%b want 0000000a/1", tohost, tohost_wr); end
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'hB || tohost_wr !== 1'b1) begin miscompares++; $display("FAIL b2b_second got %h/%b want 0000000b/1", tohost, tohost_wr); end
    @(negedge clk);
    vectors++; if (tohost_wr !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", tohost_wr); end
  endtask

  task automatic test_stall();
    logic [63:0] c0, i0;
    logic [31:0] d;
    @(negedge clk);
    c0 = exp_cycle; i0 = exp_instret;
    issue(3'b001, 12'h51E, 32'h5, 5'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (tohost !== 32'hB || tohost_wr !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d got %h/%b want 0000000b/0", k, tohost, tohost_wr); end
    end
    stall = 1'b0;
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h5 || tohost_wr !== 1'b1) begin miscompares++; $display("FAIL stall_commit got %h/%b want 00000005/1", tohost, tohost_wr); end
    rd(12'hC02, d);
    vectors++; if (d !== i0[31:0] + 32'd1) begin miscompares++; $display("FAIL stall_instret got %0d want %0d", d, i0[31:0] + 32'd1); end
    rd(12'hC00, d);
    vectors++; if (d !== c0[31:0] + 32'd4) begin miscompares++; $display("FAIL stall_cycle got %0d want %0d", d, c0[31:0] + 32'd4); end
    @(negedge clk);
    vectors++; if (tohost_wr !== 1'b0) begin miscompares++; $display("FAIL stall_once got %b want 0", tohost_wr); end
  endtask

  task automatic test_ignored();
    logic [63:0] i0;
    logic [31:0] d;
    @(negedge clk);
    issue(3'b001, 12'hC00, 32'h1234_5678, 5'h0);
    @(negedge clk);
    issue(3'b001, 12'h123, 32'h1234_5678, 5'h0);
    rd(12'hC00, d);
    vectors++; if (d !== exp_cycle[31:0]) begin miscompares++; $display("FAIL ign_cycle got %h want %h", d, exp_cycle[31:0]); end
    csr_addr = 12'h123;
    @(negedge clk);
    issue(3'b001, 12'h51E, 32'h7777_7777, 5'h0);
    valid_w = 1'b0;
    i0 = exp_instret;
    rd(12'h123, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL ign_unmapped got %h want 0", d); end
    csr_addr = 12'h51E;
    @(negedge clk);
    issue(3'b010, 12'h51E, 32'h9999_9999, 5'h3);
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h5 || tohost_wr !== 1'b0) begin miscompares++; $display("FAIL ign_tohost got %h/%b want 00000005/0", tohost, tohost_wr); end
    rd(12'hC02, d);
    vectors++; if (d !== i0[31:0] + 32'd1) begin miscompares++; $display("FAIL ign_instret got %0d want %0d", d, i0[31:0] + 32'd1); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    @(negedge clk);
    issue(3'b001, 12'h51E, 32'hCAFE_F00D, 5'h0);
    #2 rst_n = 1'b0;
    #1;
    idle();
    vectors++; if (tohost !== 32'h0 || tohost_wr !== 1'b0) begin miscompares++; $display("FAIL midrst_async got %h/%b want 0/0", tohost, tohost_wr); end
    @(negedge clk);
    rd(12'hC02, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL midrst_instret got %h want 0", d); end
    rst_n = 1'b1;
  endtask

  task automatic test_carry();
    logic [31:0] d;
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_q;
    @(negedge clk);
    rd(12'hC00, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL carry_lo got %h want 0", d); end
    rd(12'hC80, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL carry_hi got %h want 1", d); end
    rd(12'hB80, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL carry_hi_alias got %h want 1", d); end
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_csrrwi();
    test_back_to_back();
    test_stall();
    test_ignored();
    test_mid_reset();
    test_carry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
